// File: rtl/square_ctl_pkg.sv
// Shared types for the square overlay position controller.
// Wrap-around behaviour is selected with SQUARE_CTL_WRAP_EN.
package square_ctl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Signed so that a step past the left/top edge shows up as a negative candidate.
  typedef logic signed [12:0] pos_t;

  function automatic pos_t clamp_load(input logic [11:0] v, input pos_t max);
    pos_t vv;
    vv = pos_t'({1'b0, v});
    return (vv > max) ? max : vv;
  endfunction

endpackage

// File: rtl/square_ctl_if.sv
// Direction, load handshake and position bundle between the VGA pipeline and square_ctl.
interface square_ctl_if;
  logic        vblnk;
  logic        btn_up;
  logic        btn_down;
  logic        btn_left;
  logic        btn_right;
  logic        load_valid;
  logic [11:0] load_x;
  logic [11:0] load_y;
  logic        load_ready;
  logic [11:0] xpos_square;
  logic [11:0] ypos_square;
  logic        frame_tick;
  logic        moving;

  modport master (
    output vblnk, btn_up, btn_down, btn_left, btn_right,
    output load_valid, load_x, load_y,
    input  load_ready, xpos_square, ypos_square, frame_tick, moving
  );

  modport slave (
    input  vblnk, btn_up, btn_down, btn_left, btn_right,
    input  load_valid, load_x, load_y,
    output load_ready, xpos_square, ypos_square, frame_tick, moving
  );
endinterface

// File: rtl/square_ctl_axis.sv
// One-axis next-position computation: clamps to [0, max], or wraps when
// SQUARE_CTL_WRAP_EN is defined.
module square_axis
  import square_ctl_pkg::*;
(
  input  pos_t pos,
  input  logic inc,
  input  logic dec,
  input  pos_t step,
  input  pos_t max,
  output pos_t next,
  output logic moved
);

  pos_t cand;

  // Opposing requests cancel, leaving the axis still.
  always_comb begin
    cand = pos;
    if (inc && !dec)
      cand = pos + step;
    else if (dec && !inc)
      cand = pos - step;
  end

  assign moved = inc ^ dec;

`ifdef SQUARE_CTL_WRAP_EN
  always_comb begin
    next = cand;
    if (cand < 13'sd0)
      next = cand + max + 13'sd1;
    else if (cand > max)
      next = cand - max - 13'sd1;
  end
`else
  always_comb begin
    next = cand;
    if (cand < 13'sd0)
      next = 13'sd0;
    else if (cand > max)
      next = max;
  end
`endif

endmodule

// File: rtl/square_ctl.sv
// Per-frame square position controller; updates only on the vblank rising edge
// or an absolute load. Optional wrap mode: SQUARE_CTL_WRAP_EN.
module square_ctl
  import square_ctl_pkg::*;
#(
  parameter int H_ACTIVE     = 800,
  parameter int V_ACTIVE     = 600,
  parameter int WIDTH        = 8,
  parameter int HEIGHT       = 8,
  parameter int STEP         = 2,
  parameter int ACCEL_FRAMES = 16,
  parameter int INIT_X       = 396,
  parameter int INIT_Y       = 296
) (
  input logic         clk,
  input logic         rst,
  square_ctl_if.slave bus
);

  localparam pos_t       X_MAX   = pos_t'(H_ACTIVE - 1 - WIDTH);
  localparam pos_t       Y_MAX   = pos_t'(V_ACTIVE - 1 - HEIGHT);
  localparam pos_t       STEP_LO = pos_t'(STEP);
  localparam pos_t       STEP_HI = pos_t'(2 * STEP);
  localparam logic [7:0] ACCEL   = 8'(ACCEL_FRAMES);

  state_t     state;
  logic       vblnk_q;
  logic [3:0] dir_q;
  logic [7:0] hold_cnt;
  pos_t       x_q, y_q, nx_q, ny_q;
  logic       mv_q, moving_q;

  logic edge_det, load_fire, x_moved, y_moved;
  pos_t step, x_next, y_next;

  assign edge_det       = bus.vblnk & ~vblnk_q;
  assign bus.load_ready = (state == IDLE) & ~rst;
  assign load_fire      = bus.load_valid & bus.load_ready;
  assign step           = (hold_cnt < ACCEL) ? STEP_LO : STEP_HI;

  // dir_q = {up, down, left, right}; screen y grows downwards.
  square_axis u_axis_x (
    .pos(x_q), .inc(dir_q[0]), .dec(dir_q[1]), .step(step), .max(X_MAX),
    .next(x_next), .moved(x_moved)
  );

  square_axis u_axis_y (
    .pos(y_q), .inc(dir_q[2]), .dec(dir_q[3]), .step(step), .max(Y_MAX),
    .next(y_next), .moved(y_moved)
  );

  // A load in the edge cycle takes priority and swallows that frame's move.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      vblnk_q  <= 1'b0;
      dir_q    <= 4'd0;
      hold_cnt <= 8'd0;
      x_q      <= pos_t'(INIT_X);
      y_q      <= pos_t'(INIT_Y);
      nx_q     <= pos_t'(INIT_X);
      ny_q     <= pos_t'(INIT_Y);
      mv_q     <= 1'b0;
      moving_q <= 1'b0;
    end else begin
      vblnk_q <= bus.vblnk;
      case (state)
        IDLE: begin
          if (load_fire) begin
            x_q      <= clamp_load(bus.load_x, X_MAX);
            y_q      <= clamp_load(bus.load_y, Y_MAX);
            hold_cnt <= 8'd0;
          end else if (edge_det) begin
            dir_q <= {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right};
            state <= CALC;
          end
        end
        CALC: begin
          nx_q  <= x_next;
          ny_q  <= y_next;
          mv_q  <= x_moved | y_moved;
          state <= COMMIT;
        end
        COMMIT: begin
          x_q      <= nx_q;
          y_q      <= ny_q;
          moving_q <= mv_q;
          if (!mv_q)
            hold_cnt <= 8'd0;
          else if (hold_cnt < ACCEL)
            hold_cnt <= hold_cnt + 8'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.xpos_square = x_q[11:0];
  assign bus.ypos_square = y_q[11:0];
  assign bus.frame_tick  = (state == COMMIT);
  assign bus.moving      = moving_q;

endmodule

// File: tb/tb_square_ctl.sv
// Scoreboard bench for square_ctl; expectations come from an integer model
// that honours SQUARE_CTL_WRAP_EN.
module tb_square_ctl;

  localparam int X_MAX = 791;
  localparam int Y_MAX = 591;

  typedef struct {
    int x;
    int y;
    int mv;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  square_ctl_if bus ();

  square_ctl u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   m_x, m_y, m_hold, m_mv;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed != expected) begin
      bad++;
      $display("[TB] FAIL %s got=%0d want=%0d", tag, observed, expected);
    end
  endtask

  function automatic int modelAxis(input int pos, input int delta, input int max);
    int cand;
    cand = pos + delta;
`ifdef SQUARE_CTL_WRAP_EN
    if (cand < 0) return cand + max + 1;
    if (cand > max) return cand - max - 1;
`else
    if (cand < 0) return 0;
    if (cand > max) return max;
`endif
    return cand;
  endfunction

  task automatic modelFrame(input bit up, input bit dn, input bit lf, input bit rt, output exp_t e);
    int step, dx, dy;
    step = (m_hold < 16) ? 2 : 4;
    dx   = int'(rt) - int'(lf);
    dy   = int'(dn) - int'(up);
    m_x  = modelAxis(m_x, dx * step, X_MAX);
    m_y  = modelAxis(m_y, dy * step, Y_MAX);
    m_mv = (dx != 0 || dy != 0) ? 1 : 0;
    if (m_mv == 0) m_hold = 0;
    else if (m_hold < 16) m_hold++;
    e.x = m_x; e.y = m_y; e.mv = m_mv;
  endtask

  task automatic compareHead(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    checkOutput({tag, "_x"}, int'(bus.xpos_square), e.x);
    checkOutput({tag, "_y"}, int'(bus.ypos_square), e.y);
    checkOutput({tag, "_moving"}, int'(bus.moving), e.mv);
  endtask

  task automatic applyStimulus(input bit up, input bit dn, input bit lf, input bit rt,
                               input int hold_extra);
    exp_t e;
    int   waited;
    bit   seen;
    @(negedge clk);
    bus.btn_up = up; bus.btn_down = dn; bus.btn_left = lf; bus.btn_right = rt;
    bus.vblnk = 1'b1;
    modelFrame(up, dn, lf, rt, e);
    sb.push_back(e);
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < 8) begin
      @(negedge clk);
      waited++;
      if (waited == 1) checkOutput("ready_in_calc", int'(bus.load_ready), 0);
      if (bus.frame_tick) seen = 1'b1;
    end
    checkOutput("tick_latency", waited, 2);
    bus.btn_up = 0; bus.btn_down = 0; bus.btn_left = 0; bus.btn_right = 0;
    @(negedge clk);
    compareHead("frame");
    checkOutput("tick_width", int'(bus.frame_tick), 0);
    repeat (hold_extra) begin
      @(negedge clk);
      checkOutput("tick_vblnk_held", int'(bus.frame_tick), 0);
    end
    bus.vblnk = 1'b0;
  endtask

  task automatic applyLoad(input int lx, input int ly, input bit with_edge);
    exp_t e;
    @(negedge clk);
    bus.load_valid = 1'b1;
    bus.load_x = 12'(lx);
    bus.load_y = 12'(ly);
    if (with_edge) begin
      bus.vblnk = 1'b1;
      bus.btn_left = 1'b1;
    end
    checkOutput("ready_idle", int'(bus.load_ready), 1);
    m_x = (lx > X_MAX) ? X_MAX : lx;
    m_y = (ly > Y_MAX) ? Y_MAX : ly;
    m_hold = 0;
    e.x = m_x; e.y = m_y; e.mv = m_mv;
    sb.push_back(e);
    @(negedge clk);
    bus.load_valid = 1'b0;
    bus.btn_left = 1'b0;
    compareHead("load");
    if (with_edge) begin
      repeat (4) begin
        @(negedge clk);
        checkOutput("tick_dropped", int'(bus.frame_tick), 0);
      end
    end
    bus.vblnk = 1'b0;
  endtask

  initial begin
    bus.vblnk = 0; bus.btn_up = 0; bus.btn_down = 0; bus.btn_left = 0; bus.btn_right = 0;
    bus.load_valid = 0; bus.load_x = '0; bus.load_y = '0;
    m_x = 396; m_y = 296; m_hold = 0; m_mv = 0;
    repeat (3) @(negedge clk);
    checkOutput("ready_in_reset", int'(bus.load_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_x", int'(bus.xpos_square), 396);
    checkOutput("reset_y", int'(bus.ypos_square), 296);
    checkOutput("reset_ready", int'(bus.load_ready), 1);
    checkOutput("reset_tick", int'(bus.frame_tick), 0);
    checkOutput("reset_moving", int'(bus.moving), 0);

    applyStimulus(0, 0, 0, 1, 4);
    checkOutput("right_x_398", int'(bus.xpos_square), 398);

    applyLoad(1, 296, 0);
    applyStimulus(0, 0, 1, 0, 0);
`ifdef SQUARE_CTL_WRAP_EN
    checkOutput("left_edge_x", int'(bus.xpos_square), 791);
`else
    checkOutput("left_edge_x", int'(bus.xpos_square), 0);
`endif

    applyLoad(100, 296, 0);
    for (int i = 0; i < 20; i++) applyStimulus(0, 1, 0, 0, 0);
    checkOutput("down20_y_344", int'(bus.ypos_square), 344);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("step_reset_y_346", int'(bus.ypos_square), 346);

    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("updown_y", int'(bus.ypos_square), 346);

    applyLoad(1000, 50, 0);
    checkOutput("load_clamp_x", int'(bus.xpos_square), 791);
    checkOutput("load_y_50", int'(bus.ypos_square), 50);
    applyStimulus(0, 0, 1, 0, 0);
    applyLoad(1000, 50, 1);
    checkOutput("load_edge_x", int'(bus.xpos_square), 791);

    for (int i = 0; i < 8; i++)
      applyStimulus($urandom_range(0, 1), $urandom_range(0, 1),
                    $urandom_range(0, 1), $urandom_range(0, 1), 0);

    // Reset landing in the CALC cycle must abandon the update.
    @(negedge clk);
    bus.vblnk = 1'b1;
    bus.btn_right = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_calc_ready", int'(bus.load_ready), 0);
    checkOutput("rst_calc_tick", int'(bus.frame_tick), 0);
    rst = 1'b0;
    bus.vblnk = 1'b0;
    bus.btn_right = 1'b0;
    @(negedge clk);
    checkOutput("rst_calc_x", int'(bus.xpos_square), 396);
    checkOutput("rst_calc_y", int'(bus.ypos_square), 296);
    checkOutput("rst_calc_moving", int'(bus.moving), 0);
    checkOutput("rst_calc_ready_after", int'(bus.load_ready), 1);
    repeat (4) begin
      @(negedge clk);
      checkOutput("rst_calc_no_tick", int'(bus.frame_tick), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
